// File: rtl/nios_v1_mul_pkg.sv
// Shared types, latency bounds and partial-product combine for the
// nios_v1 multiply scheduler.
package nios_v1_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int unsigned MUL_LAT_MIN = 1;
  localparam int unsigned MUL_LAT_MAX = 4;

  // Wide enough to hold MUL_LAT_MAX.
  localparam int unsigned CNT_W = 3;

  // Low 32 bits of a*b from the three partial products
  // a.lo*b.lo, a.lo*b.hi, a.hi*b.lo; the a.hi*b.hi term only
  // affects bits 63:32 and all carries above bit 31 drop out.
  function automatic logic [31:0] pp_combine(
    input logic [31:0] p1,
    input logic [31:0] p2,
    input logic [31:0] p3
  );
    return p1 + ((p2 + p3) << 16);
  endfunction

endpackage

// File: rtl/nios_v1_mul_rr_arb.sv
// Two-input round-robin arbiter with one-hot grant.
// Ports: clk, reset, request[1:0], advance (served grant done), grant[1:0].
module nios_v1_mul_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester that wins a tie.
  logic prio;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      // Served 0 -> 1 gets priority; served 1 -> 0 gets it.
      prio <= grant[0];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (request[prio]) begin
      grant[prio] = 1'b1;
    end else if (request[~prio]) begin
      grant[~prio] = 1'b1;
    end
  end

endmodule

// File: rtl/nios_v1_mul_sched.sv
// Two-requester scheduler for an external 16x16 partial-product multiplier
// cell; exactly one transaction is in flight at any time.
// Ports: clk, reset; req_valid/req_ready/req_a/req_b/req_tag per requester;
// resp_valid/resp_ready per requester with shared resp_data/resp_tag;
// mul_src1/mul_src2/mul_en to the cell, mul_p1/mul_p2/mul_p3 back from it.
module nios_v1_mul_sched #(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_a,
  input  logic [1:0][31:0]      req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [31:0]           resp_data,
  output logic [TAG_W-1:0]      resp_tag,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  output logic                  mul_en,
  input  logic [31:0]           mul_p1,
  input  logic [31:0]           mul_p2,
  input  logic [31:0]           mul_p3
);

  import nios_v1_mul_pkg::*;

  if (MUL_LATENCY < MUL_LAT_MIN || MUL_LATENCY > MUL_LAT_MAX) begin : g_lat_chk
    $error("nios_v1_mul_sched: MUL_LATENCY must be 1..4");
  end

  state_t             state;
  state_t             state_nx;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        result_q;
  logic [TAG_W-1:0]   tag_q;
  logic               win_q;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic [1:0]         arb_req;
  logic [1:0]         grant;
  logic               gidx;
  logic               req_fire;
  logic               resp_fire;

  assign gidx      = grant[1];
  assign req_fire  = (state == S_IDLE) && ((req_valid & grant) != 2'b00);
  assign resp_fire = (state == S_RESP) && resp_ready[win_q];
  assign cnt_last  = (cnt == CNT_W'(1));

  // In RESP the arbiter is shown only the winner so that the grant it
  // holds at the advance edge names the requester just served.
  always_comb begin
    arb_req = 2'b00;
    unique case (state)
      S_IDLE:  arb_req = req_valid;
      S_RESP:  arb_req = {win_q, ~win_q};
      default: arb_req = 2'b00;
    endcase
  end

  nios_v1_mul_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .request (arb_req),
    .advance (resp_fire),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req_fire) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_last) state_nx = S_RESP;
      end
      S_RESP: begin
        if (resp_fire) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      win_q    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      if (req_fire) begin
        a_q   <= req_a[gidx];
        b_q   <= req_b[gidx];
        tag_q <= req_tag[gidx];
        win_q <= gidx;
      end
      if (state == S_ISSUE) begin
        cnt <= CNT_W'(MUL_LATENCY);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      // The cell has seen MUL_LATENCY enabled edges by the last
      // WAIT cycle, so its partial products are valid here.
      if (state == S_WAIT && cnt_last) begin
        result_q <= pp_combine(mul_p1, mul_p2, mul_p3);
      end
    end
  end

  // mul_en stays high through ISSUE and every WAIT cycle but the last,
  // giving the cell exactly MUL_LATENCY enabled edges.
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    mul_en     = 1'b0;
    mul_src1   = '0;
    mul_src2   = '0;
    if (!reset) begin
      unique case (state)
        S_IDLE: begin
          req_ready = grant;
        end
        S_ISSUE: begin
          mul_en   = 1'b1;
          mul_src1 = a_q;
          mul_src2 = b_q;
        end
        S_WAIT: begin
          mul_en   = !cnt_last;
          mul_src1 = a_q;
          mul_src2 = b_q;
        end
        S_RESP: begin
          resp_valid[win_q] = 1'b1;
        end
        default: begin
          req_ready = 2'b00;
        end
      endcase
    end
  end

  assign resp_data = reset ? '0 : result_q;
  assign resp_tag  = reset ? '0 : tag_q;

endmodule

// File: tb/tb_nios_v1_mul_sched.sv
// Randomised self-checking bench for nios_v1_mul_sched with a
// transaction-level reference model and a pipelined cell model.
module tb_nios_v1_mul_sched;

  localparam int L  = 3;
  localparam int TW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][31:0]    req_a;
  logic [1:0][31:0]    req_b;
  logic [1:0][TW-1:0]  req_tag;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [31:0]         resp_data;
  logic [TW-1:0]       resp_tag;
  logic [31:0]         mul_src1;
  logic [31:0]         mul_src2;
  logic                mul_en;
  logic [31:0]         mul_p1;
  logic [31:0]         mul_p2;
  logic [31:0]         mul_p3;

  always #5 clk = ~clk;

  nios_v1_mul_sched #(
    .MUL_LATENCY (L),
    .TAG_W       (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_en     (mul_en),
    .mul_p1     (mul_p1),
    .mul_p2     (mul_p2),
    .mul_p3     (mul_p3)
  );

  // Cell model: L-stage pipeline advancing only on enabled edges.
  logic [31:0] pipe1 [L];
  logic [31:0] pipe2 [L];
  logic [31:0] pipe3 [L];

  always @(posedge clk) begin
    if (mul_en) begin
      pipe1[0] <= {16'h0, mul_src1[15:0]} * {16'h0, mul_src2[15:0]};
      pipe2[0] <= {16'h0, mul_src1[15:0]} * {16'h0, mul_src2[31:16]};
      pipe3[0] <= {16'h0, mul_src1[31:16]} * {16'h0, mul_src2[15:0]};
      for (int k = 1; k < L; k++) begin
        pipe1[k] <= pipe1[k-1];
        pipe2[k] <= pipe2[k-1];
        pipe3[k] <= pipe3[k-1];
      end
    end
  end

  assign mul_p1 = pipe1[L-1];
  assign mul_p2 = pipe2[L-1];
  assign mul_p3 = pipe3[L-1];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one job in flight, t = edges since its handshake.
  bit             busy = 1'b0;
  int             t    = 0;
  bit             pidx = 1'b0;
  logic [31:0]    pa   = '0;
  logic [31:0]    pb   = '0;
  logic [TW-1:0]  ptag = '0;
  bit             lst  = 1'b1;
  bit             hs   = 1'b0;
  bit             hs_idx = 1'b0;
  int             n_done = 0;

  // Check outputs of the current cycle, then take one clock edge.
  task automatic tick();
    logic [1:0]  g;
    logic [1:0]  rv;
    logic [31:0] prod;
    bit          act;
    bit          dn;
    #1;
    g  = 2'b00;
    rv = 2'b00;
    if (!reset && !busy) begin
      if (req_valid == 2'b11) g = lst ? 2'b01 : 2'b10;
      else                    g = req_valid;
    end
    if (!reset && busy && t >= L + 2) rv[pidx] = 1'b1;
    prod = pa * pb;
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("resp_valid", 32'(resp_valid), 32'(rv));
    if (reset) begin
      chk("rst_resp_data", resp_data, 32'h0);
      chk("rst_resp_tag", 32'(resp_tag), 32'h0);
    end else if (rv != 2'b00) begin
      chk("resp_data", resp_data, prod);
      chk("resp_tag", 32'(resp_tag), 32'(ptag));
    end
    act = !reset && busy && t >= 1 && t <= L + 1;
    chk("mul_en", 32'(mul_en), 32'(act && t <= L));
    chk("mul_src1", mul_src1, act ? pa : 32'h0);
    chk("mul_src2", mul_src2, act ? pb : 32'h0);
    dn     = (rv != 2'b00) && resp_ready[pidx];
    hs     = (g != 2'b00);
    hs_idx = g[1];
    @(posedge clk);
    if (reset) begin
      busy = 1'b0;
      lst  = 1'b1;
      hs   = 1'b0;
    end else if (hs) begin
      busy = 1'b1;
      t    = 1;
      pidx = hs_idx;
      pa   = req_a[hs_idx];
      pb   = req_b[hs_idx];
      ptag = req_tag[hs_idx];
    end else if (dn) begin
      busy = 1'b0;
      lst  = pidx;
      n_done++;
    end else if (busy) begin
      t++;
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    unique case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input bit idx, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tg,
                        input logic [31:0] exp);
    int n;
    int en_cnt;
    req_a[idx]     = a;
    req_b[idx]     = b;
    req_tag[idx]   = tg;
    req_valid[idx] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hs && n < 20);
    req_valid[idx] = 1'b0;
    chk("op_handshake", 32'(hs), 32'h1);
    n      = 1;
    en_cnt = 0;
    while (!resp_valid[idx] && n < 40) begin
      if (mul_en) en_cnt++;
      tick();
      n++;
    end
    chk("op_latency", 32'(n), 32'(L + 2));
    chk("op_mul_en_cycles", 32'(en_cnt), 32'(L));
    chk("op_data", resp_data, exp);
    chk("op_tag", 32'(resp_tag), 32'(tg));
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("op_done", 32'(busy), 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || req_valid != 2'b00) && n < 200) begin
      tick();
      if (hs) req_valid[hs_idx] = 1'b0;
      n++;
    end
    chk("drain_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    int  k;
    int  n;
    bit  prev;
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    resp_ready = 2'b00;
    prev       = 1'b0;

    tick();
    tick();
    reset = 1'b0;
    tick();

    // Directed values with the response accepted at once.
    resp_ready = 2'b11;
    run_op(1'b0, 32'd3, 32'd5, 4'h2, 32'h0000_000F);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h5, 32'h0000_0001);
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 4'hA, 32'h0000_0000);

    // Both requesters held valid: grants must alternate.
    for (int i = 0; i < 2; i++) begin
      req_a[i]     = rnd_op();
      req_b[i]     = rnd_op();
      req_tag[i]   = TW'($urandom);
      req_valid[i] = 1'b1;
    end
    k = 0;
    n = 0;
    while (k < 6 && n < 200) begin
      tick();
      n++;
      if (hs) begin
        if (k > 0) chk("rr_alternate", 32'(hs_idx), 32'(!prev));
        prev = hs_idx;
        k++;
        req_a[hs_idx]   = rnd_op();
        req_b[hs_idx]   = rnd_op();
        req_tag[hs_idx] = TW'($urandom);
      end
    end
    chk("rr_grants", 32'(k), 32'd6);
    req_valid = 2'b00;
    drain();

    // Response stalled for 10 cycles; the other side's ready is ignored.
    resp_ready   = 2'b10;
    req_a[0]     = 32'd1234;
    req_b[0]     = 32'd5678;
    req_tag[0]   = 4'h7;
    req_valid[0] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hs && n < 20);
    req_valid[0] = 1'b0;
    req_a[1]     = 32'd9;
    req_b[1]     = 32'd9;
    req_tag[1]   = 4'h9;
    req_valid[1] = 1'b1;
    n = 0;
    while (!resp_valid[0] && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", 32'(resp_valid), 32'h1);
      chk("stall_data", resp_data, 32'd7006652);
    end
    resp_ready = 2'b01;
    tick();
    chk("stall_release", 32'(resp_valid), 32'h0);
    resp_ready = 2'b11;
    drain();

    // Reset pulse during WAIT aborts the job.
    req_a[0]     = 32'd77;
    req_b[0]     = 32'd11;
    req_tag[0]   = 4'h3;
    req_valid[0] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hs && n < 20);
    req_valid[0] = 1'b0;
    n = 0;
    while (t < 3 && n < 20) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_resp", 32'(resp_valid), 32'h0);
    end
    run_op(1'b1, 32'h8000_0001, 32'h0000_0003, 4'hC, 32'h8000_0003);

    // Random traffic, random back-pressure and occasional reset.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_a[i]     = rnd_op();
          req_b[i]     = rnd_op();
          req_tag[i]   = TW'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = 2'($urandom);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
      if (hs) req_valid[hs_idx] = 1'b0;
    end
    reset      = 1'b0;
    resp_ready = 2'b11;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/nios_v1_mul_sched.md
NIOS_V1_MUL_SCHED -- requirements
Module: nios_v1_mul_sched

Interface
REQ-001 The module SHALL have parameter MUL_LATENCY, default 1: clock cycles from the enabled edge of mul_en until mul_p1/p2/p3 are valid; legal range 1..4.
REQ-002 The module SHALL have parameter TAG_W, default 4: width of each requester's transaction tag.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  2  per-requester operation request (index 0, 1).
REQ-006 req_ready  output  2  per-requester request accept; a transfer occurs when valid & ready are both high.
REQ-007 req_a, req_b  input  2x32 each  per-requester operands.
REQ-008 req_tag  input  2xTAG_W  per-requester tag, returned unchanged with the result.
REQ-009 resp_valid  output  2  per-requester result valid.
REQ-010 resp_ready  input  2  per-requester result accept.
REQ-011 resp_data  output  32  low 32 bits of a*b; shared by both requesters.
REQ-012 resp_tag  output  TAG_W  tag of the current response.
REQ-013 mul_src1, mul_src2  output  32 each  operands driven to the 16x16 partial-product multiplier cell.
REQ-014 mul_en  output  1  multiplier pipeline enable.
REQ-015 mul_p1, mul_p2, mul_p3  input  32 each  partial products from the cell: a.lo*b.lo, a.lo*b.hi, a.hi*b.lo.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: req_ready SHALL be high only for the arbitration winner; on a handshake, the block SHALL latch a, b, tag and the winner index, then go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: if both requesters are valid, the one not served last wins; after reset, requester 0 has priority.
REQ-019 ISSUE: mul_src1/mul_src2 SHALL carry the latched operands, mul_en=1 for exactly one cycle, the latency counter SHALL load MUL_LATENCY, and the FSM SHALL go to WAIT.
REQ-020 WAIT: mul_en SHALL stay 1 and mul_src1/mul_src2 SHALL hold until the counter expires, so the cell pipeline advances. In the expiry cycle the block SHALL capture result = (mul_p1 + ((mul_p2 + mul_p3) << 16)) mod 2^32 into a register, then go to RESP.
REQ-021 RESP: resp_valid[winner] SHALL be 1 and resp_data/resp_tag SHALL hold stable until resp_ready[winner] is high. Then: go to IDLE, update the round-robin pointer, and drop resp_valid.
REQ-022 Outside ISSUE/WAIT, mul_en SHALL be 0.
REQ-023 At most one transaction SHALL be outstanding; req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-024 resp_ready of the non-winning requester SHALL be ignored; resp_valid SHALL never be high on both bits at once.
REQ-025 Throughput SHALL be one operation per MUL_LATENCY+3 cycles when resp_ready is held high.
REQ-026 The carry out of bit 31 in the addition SHALL be discarded; the result is valid for both signed and unsigned operands.

Reset
REQ-027 While reset is high, the block SHALL force: state=IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_tag=0, mul_en=0, mul_src1/mul_src2=0, rr pointer=requester 0, latency counter=0.
REQ-028 Reset asserted mid-operation (ISSUE, WAIT, RESP) SHALL abort the transaction with no response delivered; the first post-reset cycle is IDLE.
REQ-029 req_ready SHALL be 0 during the reset cycle and may rise in the cycle after reset deasserts.

Structure
REQ-030 The state enum, MUL_LATENCY bounds and the partial-product combine function SHALL reside in shared package nios_v1_mul_pkg.
REQ-031 The two-input round-robin arbiter SHALL be a separate sub-module, nios_v1_mul_rr_arb (inputs: request, advance; output: one-hot grant).
REQ-032 The multiplier cell itself SHALL NOT be instantiated inside this block; it is connected at the parent level.

Verification
REQ-033 Requester 0: a=3, b=5, tag=0x2, resp_ready=1 -> resp_valid[0] exactly MUL_LATENCY+2 cycles after the handshake, resp_data=0x0000000F, resp_tag=0x2.
REQ-034 a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_data=0x00000001; a=0x00010000, b=0x00010000 -> resp_data=0x00000000.
REQ-035 Both requesters held valid continuously -> grants alternate 0,1,0,1; each response goes to the correct index with its own tag.
REQ-036 resp_ready[0] held low for 10 cycles in RESP -> resp_valid/resp_data/resp_tag stable, req_ready=0 and mul_en=0 throughout; completion follows resp_ready rising.
REQ-037 reset pulsed for 1 cycle during WAIT -> no resp_valid, all outputs at reset values, next request completes normally.
REQ-038 MUL_LATENCY=3 build -> mul_en high for 3 consecutive cycles, with the result captured in the cycle the counter expires.
